scroll_sequencer: RTL
=====================

SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, base clock cycles per scroll step at speed 0; SHALL be >= 8.
REQ-002 clk  input  1  system clock; all state SHALL change on rising edge only, except reset.
REQ-003 aclr  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  level; 1 = auto-scroll, 0 = stopped; asynchronous source.
REQ-005 dir  input  1  level; 0 = offset increments, 1 = offset decrements; asynchronous source.
REQ-006 step  input  1  level; each 0->1 transition requests one manual advance; asynchronous source.
REQ-007 speed  input  2  quasi-static divisor select; used directly without a synchronizer.
REQ-008 offset  output  2  current scroll position.
REQ-009 char_hex3, char_hex2, char_hex1, char_hex0  output  2 each  character code per digit, HEX3 = leftmost.
REQ-010 tick  output  1  one-cycle pulse, high in the cycle the new offset first appears.
REQ-011 state  output  2  FSM state: STOP = 00, RUN = 01, STEP = 10; 11 unused.

Function
REQ-012 run, dir and step SHALL each pass through a 2-flop synchronizer; the synchronized values are run_s, dir_s and step_s.
REQ-013 step_p SHALL equal step_s AND NOT step_d, where step_d is step_s delayed one cycle.
  - A step held high SHALL produce exactly one step_p.
REQ-014 LIMIT SHALL equal TICK_DIV >> speed, re-evaluated every cycle.
REQ-015 The prescaler SHALL be a counter of width clogb2(TICK_DIV-1) bits that counts only in RUN.
REQ-016 In STOP and STEP the prescaler SHALL be held at 0.
REQ-017 Advance SHALL be offset+1 mod 4 when dir_s = 0, and offset-1 mod 4 when dir_s = 1.
  - Wrap in both directions: 3->0 and 0->3.
REQ-018 Character mapping SHALL be combinational from offset:
  - char_hex3 = offset
  - char_hex2 = offset+1 mod 4
  - char_hex1 = offset+2 mod 4
  - char_hex0 = offset+3 mod 4
REQ-019 STOP transitions SHALL be, in priority order:
  - step_p = 1 -> STEP, with advance and tick registered on the same edge;
  - else run_s = 1 -> RUN;
  - else stay.
REQ-020 STEP SHALL last exactly one cycle, then go to RUN if run_s = 1, else STOP; no further advance.
REQ-021 RUN behaviour:
  - run_s = 0 -> STOP, no advance, even if the prescaler is at LIMIT-1;
  - else if prescaler >= LIMIT-1 -> prescaler := 0, advance, tick registered high;
  - else prescaler := prescaler + 1.
REQ-022 step_p in RUN or STEP SHALL be ignored and SHALL NOT be queued.
REQ-023 The prescaler comparison SHALL use >=, so a speed change that lowers LIMIT below the current count causes an advance on the next edge.
REQ-024 A dir change SHALL affect only advances occurring after dir_s changes; offset never jumps on a dir change alone.
REQ-025 tick SHALL be registered: high exactly one cycle per advance, low otherwise.
REQ-026 Manual-step latency: step rising before edge n -> offset and tick update at edge n+2 (third edge counting n).
REQ-027 Auto-scroll timing: the first advance SHALL occur LIMIT cycles after entering RUN; subsequent advances SHALL occur every LIMIT cycles.

Reset
REQ-028 While aclr = 0, the following SHALL be forced immediately, independent of clk:
  - offset = 0, state = STOP, prescaler = 0, tick = 0;
  - all synchronizer and step_d flops = 0;
  - char_hex3..0 = 0, 1, 2, 3.
REQ-029 After aclr release, a step input already high SHALL generate one step_p, since the synchronizer restarts from 0.
REQ-030 Reset mid-operation SHALL abandon any pending advance; no tick SHALL be emitted.

Verification (TICK_DIV = 8)
REQ-031 aclr low during RUN with offset 2 -> offset 0, chars 0/1/2/3, state 00, tick 0, all without a clock edge.
REQ-032 run = 1, dir = 0, speed = 0 -> state 01 two edges after run; tick every 8 cycles; offset 0,1,2,3,0.
REQ-033 run = 1, dir = 1 from offset 0 -> offset 3,2,1,0; char_hex0 sequence 2,1,0,3.
REQ-034 speed = 2 -> tick period 2; switch speed 0->3 when prescaler = 5 -> advance on the next edge, then period 1.
REQ-035 In STOP, step held high for 20 cycles -> exactly one advance, 0->1, on the third edge, one tick; step during RUN -> no extra advance.
REQ-036 run_s falls in the same cycle the prescaler = 7 -> state 00, offset unchanged, no tick.

Source files
------------

// File: rtl/scroll_sequencer.sv
// scroll_sequencer
//   Four-digit scrolling character sequencer. A 2-bit offset advances either
//   automatically (prescaled from clk) or by a manual step pulse. The four
//   digit outputs show the offset and its three successors, so the pattern
//   0,1,2,3 rotates across HEX3..HEX0.
//
// Parameters
//   TICK_DIV   clk cycles per advance at speed 0 (must be >= 8)
//
// Ports
//   clk        system clock, rising edge
//   aclr       asynchronous reset, active low
//   run        auto-scroll enable (asynchronous level)
//   dir        0 = offset counts up, 1 = offset counts down (asynchronous level)
//   step       each rising edge requests one manual advance (asynchronous level)
//   speed      prescaler divisor select, period = TICK_DIV >> speed (quasi-static)
//   offset     current scroll position
//   char_hex3..char_hex0  character code per digit, HEX3 leftmost
//   tick       one-cycle pulse in the cycle a new offset first appears
//   state      FSM state: 00 STOP, 01 RUN, 10 STEP
module scroll_sequencer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       aclr,
   input  logic       run,
   input  logic       dir,
   input  logic       step,
   input  logic [1:0] speed,
   output logic [1:0] offset,
   output logic [1:0] char_hex3,
   output logic [1:0] char_hex2,
   output logic [1:0] char_hex1,
   output logic [1:0] char_hex0,
   output logic       tick,
   output logic [1:0] state
);

   // Number of bits needed to hold the value passed in.
   function automatic int clogb2(input int value);
      int v;
      int bits;
      v    = value;
      bits = 0;
      while (v > 0) begin
         bits = bits + 1;
         v    = v >> 1;
      end
      return bits;
   endfunction

   localparam int PW = clogb2(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   // Two-flop synchronizers plus the step edge-detect flop.
   logic run_meta_reg, run_s_reg;
   logic dir_meta_reg, dir_s_reg;
   logic step_meta_reg, step_s_reg, step_d_reg;
   logic step_p;

   state_t        state_reg, state_next;
   logic [1:0]    offset_reg, offset_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic          tick_reg, tick_next;

   logic [31:0]   limit;
   logic [1:0]    offset_adv;
   logic          presc_done;

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         run_meta_reg  <= 1'b0;
         run_s_reg     <= 1'b0;
         dir_meta_reg  <= 1'b0;
         dir_s_reg     <= 1'b0;
         step_meta_reg <= 1'b0;
         step_s_reg    <= 1'b0;
         step_d_reg    <= 1'b0;
      end else begin
         run_meta_reg  <= run;
         run_s_reg     <= run_meta_reg;
         dir_meta_reg  <= dir;
         dir_s_reg     <= dir_meta_reg;
         step_meta_reg <= step;
         step_s_reg    <= step_meta_reg;
         step_d_reg    <= step_s_reg;
      end
   end

   assign step_p = step_s_reg & ~step_d_reg;

   // Period shrinks with speed; evaluated every cycle so a speed change acts at once.
   assign limit      = 32'(TICK_DIV) >> speed;
   // ">=" rather than "==" so a count stranded above a freshly lowered limit
   // still fires on the next edge instead of wrapping the whole counter.
   assign presc_done = 32'(presc_reg) >= (limit - 32'd1);
   // 2-bit arithmetic wraps naturally: 3->0 going up, 0->3 going down.
   assign offset_adv = dir_s_reg ? (offset_reg - 2'd1) : (offset_reg + 2'd1);

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_reg  <= ST_STOP;
         offset_reg <= 2'd0;
         presc_reg  <= '0;
         tick_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         offset_reg <= offset_next;
         presc_reg  <= presc_next;
         tick_reg   <= tick_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      offset_next = offset_reg;
      presc_next  = presc_reg;
      tick_next   = 1'b0;
      case (state_reg)
         ST_STOP: begin
            presc_next = '0;
            if (step_p) begin
               // Manual advance happens on the edge that enters STEP.
               state_next  = ST_STEP;
               offset_next = offset_adv;
               tick_next   = 1'b1;
            end else if (run_s_reg) begin
               state_next = ST_RUN;
            end
         end
         ST_STEP: begin
            presc_next = '0;
            state_next = run_s_reg ? ST_RUN : ST_STOP;
         end
         ST_RUN: begin
            // step_p is deliberately ignored here and not remembered.
            if (!run_s_reg) begin
               state_next = ST_STOP;
               presc_next = '0;
            end else if (presc_done) begin
               presc_next  = '0;
               offset_next = offset_adv;
               tick_next   = 1'b1;
            end else begin
               presc_next = presc_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_STOP;
            presc_next = '0;
         end
      endcase
   end

   assign offset    = offset_reg;
   assign tick      = tick_reg;
   assign state     = state_reg;
   assign char_hex3 = offset_reg;
   assign char_hex2 = offset_reg + 2'd1;
   assign char_hex1 = offset_reg + 2'd2;
   assign char_hex0 = offset_reg + 2'd3;

endmodule
